// File: rtl/uart_rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_pkg
// Description : Shared UART receive definitions: baud constants, default
//               frame width, receive FSM state encoding and parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_frame_pkg;

    // 50 MHz / 9600 baud, and the half-bit offset used for mid-bit sampling
    localparam int BPS_DIV    = 5208;
    localparam int BPS_HALF   = 2604;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Parity over up to 9 data bits; unused upper bits are zero and do not
    // disturb the XOR reduction.
    function automatic logic calc_parity(input logic [8:0] bits, input logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_if
// Description : Serial line, baud tick handshake and received-byte status
//               bundle of the UART receive framer.
//               master = environment (pin, tick generator, byte consumer)
//               slave  = the framer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_if #(
    parameter int DATA_W = 8
) ();
    logic              rx_in;
    logic              clk_bps;
    logic              bps_start;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              parity_err;
    logic              rx_busy;

    modport master (
        output rx_in, clk_bps,
        input  bps_start, rx_data, rx_valid, frame_err, parity_err, rx_busy
    );

    modport slave (
        input  rx_in, clk_bps,
        output bps_start, rx_data, rx_valid, frame_err, parity_err, rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the raw rx pin plus one history
//               flop for falling-edge detection. Flops reset to the idle
//               level (1) so reset release never fakes a start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_fall
);
    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Synchronize the asynchronous line and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= rx_in;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign rx_s    = r_sync;
    assign rx_fall = r_hist & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : UART receive framer. Detects the start edge, requests the
//               mid-bit tick via bps_start, shifts in LSB-first data on each
//               clk_bps, checks stop (and optional parity) and presents the
//               byte with a one-cycle valid strobe or an error strobe.
//               Optional feature macro: UART_RX_PARITY_EN (adds PARITY state).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_frame_if.slave rx
);
    logic              w_rx_s;
    logic              w_rx_fall;

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic              r_bps_start;
    logic              w_bps_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic [DATA_W-1:0] r_rx_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic [3:0]        r_bitcnt;
    logic [3:0]        w_bitcnt_nxt;
    logic              r_rx_valid;
    logic              w_valid_nxt;
    logic              r_frame_err;
    logic              w_ferr_nxt;
    logic              r_parity_err;
    logic              w_perr_nxt;
    logic              w_par_bad;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_in   (rx.rx_in),
        .rx_s    (w_rx_s),
        .rx_fall (w_rx_fall)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic w_par_nxt;

    assign w_par_bad = (calc_parity(9'(r_shreg), PARITY_ODD) != r_par_bit);

    // Received parity bit, captured in the PARITY state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bit <= 1'b0;
        end else begin
            r_par_bit <= w_par_nxt;
        end
    end
`else
    logic w_unused_parity;

    assign w_unused_parity = PARITY_ODD;
    assign w_par_bad       = 1'b0;
`endif

    // State, shifter, counter and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bps_start  <= 1'b0;
            r_shreg      <= '0;
            r_rx_data    <= '0;
            r_bitcnt     <= 4'd0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bps_start  <= w_bps_nxt;
            r_shreg      <= w_shreg_nxt;
            r_rx_data    <= w_data_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_rx_valid   <= w_valid_nxt;
            r_frame_err  <= w_ferr_nxt;
            r_parity_err <= w_perr_nxt;
        end
    end

    // Next-state and next-output decode; strobes default low so they last one cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_bps_nxt    = r_bps_start;
        w_shreg_nxt  = r_shreg;
        w_data_nxt   = r_rx_data;
        w_bitcnt_nxt = r_bitcnt;
        w_valid_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_perr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt    = r_par_bit;
`endif
        case (r_state)
            ST_IDLE: begin
                // Ticks are ignored here; only a fresh falling edge starts a frame
                if (w_rx_fall) begin
                    w_bps_nxt    = 1'b1;
                    w_bitcnt_nxt = 4'd0;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (rx.clk_bps) begin
                    if (w_rx_s) begin
                        // Line back high at mid start bit: glitch, not a frame
                        w_bps_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx.clk_bps) begin
                    w_shreg_nxt  = {w_rx_s, r_shreg[DATA_W-1:1]};
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (rx.clk_bps) begin
                    w_par_nxt   = w_rx_s;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (rx.clk_bps) begin
                    w_bps_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    // A bad stop bit outranks a parity mismatch
                    if (!w_rx_s) begin
                        w_ferr_nxt = 1'b1;
                    end else if (w_par_bad) begin
                        w_perr_nxt = 1'b1;
                    end else begin
                        w_data_nxt  = r_shreg;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_bps_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rx.bps_start  = r_bps_start;
    assign rx.rx_data    = r_rx_data;
    assign rx.rx_valid   = r_rx_valid;
    assign rx.frame_err  = r_frame_err;
    assign rx.parity_err = r_parity_err;
    assign rx.rx_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Self-checking bench for uart_rx_frame with a scaled-down
//               baud tick generator (32 clk/bit) and a status scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int DIV  = 32;
    localparam int HALF = 16;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FERR  = 2'd1;
    localparam logic [1:0] K_PERR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       bps;
    } ev_t;

    logic clk;
    logic rst_n;
    int   r_cnt;
    int   n_cmp;
    int   n_bad;
    int   viol;
    logic prev_pulse;
    logic [7:0] m_last;

    ev_t exp_q[$];
    ev_t obs_q[$];

    uart_rx_frame_if #(.DATA_W(8)) bus ();

    uart_rx_frame #(
        .DATA_W     (8),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick model: mid-bit pulse while bps_start is held
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_cnt <= 0;
        else if (!bus.bps_start)   r_cnt <= 0;
        else if (r_cnt == DIV - 1) r_cnt <= 0;
        else                       r_cnt <= r_cnt + 1;
    end
    assign bus.clk_bps = bus.bps_start && (r_cnt == HALF);

    // Status monitor: record every strobe and note exclusivity violations
    always @(negedge clk) begin
        logic any;
        ev_t  o;
        any = bus.rx_valid | bus.frame_err | bus.parity_err;
        if (!rst_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (any) begin
                o.kind = bus.rx_valid ? K_VALID : (bus.frame_err ? K_FERR : K_PERR);
                o.data = bus.rx_data;
                o.bps  = bus.bps_start;
                obs_q.push_back(o);
                if ((int'(bus.rx_valid) + int'(bus.frame_err) + int'(bus.parity_err)) > 1) viol++;
                if (prev_pulse) viol++;
            end
            prev_pulse = any;
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        bus.rx_in = b;
        repeat (DIV - 1) @(negedge clk);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return (ones % 2) == 1;
    endfunction

    // Push the expected outcome, then serialize start, data, [parity], stop
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        ev_t e;
        e.bps = 1'b0;
        if (!stop) begin
            e.kind = K_FERR; e.data = m_last;
`ifdef UART_RX_PARITY_EN
        end else if (par_flip) begin
            e.kind = K_PERR; e.data = m_last;
`endif
        end else begin
            e.kind = K_VALID; e.data = d; m_last = d;
        end
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(even_par(d) ^ par_flip);
`endif
        drive_bit(stop);
    endtask

    task automatic drain(input string name);
        int   waited;
        ev_t  e;
        ev_t  o;
        waited = 0;
        while (obs_q.size() < exp_q.size() && waited < 4 * DIV) begin
            @(negedge clk);
            waited++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s: no status pulse, want kind=%0d data=0x%02h", name, e.kind, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL %s: got kind=%0d data=0x%02h bps=%0b, want kind=%0d data=0x%02h bps=%0b",
                             name, o.kind, o.data, o.bps, e.kind, e.data, e.bps);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d unexpected status pulse(s), want 0", name, obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic [7:0] want_data);
        n_cmp++; if (bus.bps_start  !== 1'b0)  begin n_bad++; $display("FAIL %s bps_start: got %b want 0", name, bus.bps_start); end
        n_cmp++; if (bus.rx_busy    !== 1'b0)  begin n_bad++; $display("FAIL %s rx_busy: got %b want 0", name, bus.rx_busy); end
        n_cmp++; if (bus.rx_valid   !== 1'b0)  begin n_bad++; $display("FAIL %s rx_valid: got %b want 0", name, bus.rx_valid); end
        n_cmp++; if (bus.frame_err  !== 1'b0)  begin n_bad++; $display("FAIL %s frame_err: got %b want 0", name, bus.frame_err); end
        n_cmp++; if (bus.parity_err !== 1'b0)  begin n_bad++; $display("FAIL %s parity_err: got %b want 0", name, bus.parity_err); end
        n_cmp++; if (bus.rx_data    !== want_data) begin n_bad++; $display("FAIL %s rx_data: got 0x%02h want 0x%02h", name, bus.rx_data, want_data); end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.rx_in = 1'b1;
        m_last    = 8'h00;
        repeat (5) @(negedge clk);
        check_idle_outputs("reset", 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.bps_start !== 1'b0) begin n_bad++; $display("FAIL reset_release bps_start: got %b want 0", bus.bps_start); end
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1, 1'b0);
        drain("basic_0x55");
    endtask

    task automatic test_false_start();
        int waited;
        @(negedge clk);
        bus.rx_in = 1'b0;
        repeat (6) @(negedge clk);
        bus.rx_in = 1'b1;
        n_cmp++; if (bus.bps_start !== 1'b1) begin n_bad++; $display("FAIL false_start rise: bps_start got %b want 1", bus.bps_start); end
        waited = 0;
        while (!bus.clk_bps && waited < 2 * DIV) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (waited >= 2 * DIV) begin n_bad++; $display("FAIL false_start tick: no clk_bps within %0d cycles", 2 * DIV); end
        @(negedge clk);
        n_cmp++; if (bus.bps_start !== 1'b0) begin n_bad++; $display("FAIL false_start fall: bps_start got %b want 0", bus.bps_start); end
        n_cmp++; if (bus.rx_busy !== 1'b0) begin n_bad++; $display("FAIL false_start busy: rx_busy got %b want 0", bus.rx_busy); end
        repeat (2 * DIV) @(negedge clk);
        drain("false_start");
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (30 * DIV) @(negedge clk);
        n_cmp++; if (bus.bps_start !== 1'b0) begin n_bad++; $display("FAIL stuck_low bps_start: got %b want 0", bus.bps_start); end
        n_cmp++; if (bus.rx_data !== 8'h55) begin n_bad++; $display("FAIL stuck_low rx_data: got 0x%02h want 0x55", bus.rx_data); end
        bus.rx_in = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        drain("frame_err");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        repeat (DIV / 2) @(negedge clk);
        n_cmp++; if (bus.rx_busy !== 1'b1) begin n_bad++; $display("FAIL mid_frame busy: rx_busy got %b want 1", bus.rx_busy); end
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset", 8'h00);
        m_last    = 8'h00;
        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10 * DIV) @(negedge clk);
        drain("reset_discard");
        send_frame(8'h81, 1'b1, 1'b0);
        drain("after_reset_0x81");
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drain("parity_bad_0x07");
        send_frame(8'h07, 1'b1, 1'b0);
        drain("parity_good_0x07");
`else
        send_frame(8'h5A, 1'b1, 1'b0);
        drain("no_parity_0x5A");
`endif
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL strobe_exclusive: got %0d overlapping/consecutive strobes want 0", viol);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        viol       = 0;
        prev_pulse = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
